// File: rtl/dmi_arbiter.sv
// Round-robin 2:1 DMI arbiter (port 0 = JTAG DTM, port 1 = debug bridge), one transaction in flight.
// Latency: 3 cycles minimum per transaction; requests stall while busy, responses stall on owner ready.
// Optional response watchdog (TOUT state, resp_err_o) enabled by defining DMI_ARB_TIMEOUT_EN.
module dmi_arbiter #(
  parameter type         req_t          = logic,
  parameter type         resp_t         = logic,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       dmi_clear_i,
  input  req_t       req_i [1:0],
  input  logic [1:0] req_valid_i,
  output logic [1:0] req_ready_o,
  output resp_t      resp_o [1:0],
  output logic [1:0] resp_valid_o,
  input  logic [1:0] resp_ready_i,
  output logic [1:0] resp_err_o,
  output logic       dmi_clear_o,
  output req_t       dmi_req_o,
  output logic       dmi_req_valid_o,
  input  logic       dmi_req_ready_i,
  input  resp_t      dmi_resp_i,
  input  logic       dmi_resp_valid_i,
  output logic       dmi_resp_ready_o,
  output logic       busy_o,
  output logic       owner_o
);

`ifdef DMI_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, TOUT = 2'd3} state_e;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_e;
`endif

  state_e state_q, state_d;
  logic   owner_q, last_q, last_d;
  logic   clear_q;
  req_t   req_q;
  logic   gnt_vld;
  logic   gnt_idx;

  // Both valid: the port that did not complete last wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    if (state_q == IDLE && !dmi_clear_i) begin
      if (req_valid_i == 2'b11) begin
        gnt_vld = 1'b1;
        gnt_idx = ~last_q;
      end else if (req_valid_i[0]) begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b0;
      end else if (req_valid_i[1]) begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    req_ready_o      = 2'b00;
    resp_o[0]        = '0;
    resp_o[1]        = '0;
    resp_valid_o     = 2'b00;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
    resp_err_o       = 2'b00;
`endif
    case (state_q)
      IDLE: begin
        dmi_resp_ready_o = 1'b1;
        if (gnt_vld) begin
          req_ready_o[gnt_idx] = 1'b1;
          state_d              = REQ;
        end
      end
      REQ: begin
        // Clear takes priority over the downstream handshake.
        if (!dmi_clear_i) begin
          dmi_req_valid_o = 1'b1;
          if (dmi_req_ready_i) state_d = RESP;
        end
      end
      RESP: begin
        if (!dmi_clear_i) begin
          resp_o[owner_q]       = dmi_resp_i;
          resp_valid_o[owner_q] = dmi_resp_valid_i;
          dmi_resp_ready_o      = resp_ready_i[owner_q];
          if (dmi_resp_valid_i && resp_ready_i[owner_q]) begin
            last_d  = owner_q;
            state_d = IDLE;
          end
`ifdef DMI_ARB_TIMEOUT_EN
          else if (!dmi_resp_valid_i && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = TOUT;
          end
`endif
        end
      end
`ifdef DMI_ARB_TIMEOUT_EN
      TOUT: begin
        if (!dmi_clear_i) begin
          resp_valid_o[owner_q] = 1'b1;
          resp_err_o[owner_q]   = 1'b1;
          dmi_resp_ready_o      = 1'b1;
          if (resp_ready_i[owner_q]) begin
            last_d  = owner_q;
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (dmi_clear_i) state_d = IDLE;
  end

`ifndef DMI_ARB_TIMEOUT_EN
  assign resp_err_o = 2'b00;
`endif

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      req_q   <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      clear_q <= dmi_clear_i;
      if (gnt_vld) begin
        req_q   <= req_i[gnt_idx];
        owner_q <= gnt_idx;
      end
    end
  end

`ifdef DMI_ARB_TIMEOUT_EN
  // Counts RESP cycles spent waiting; restarts on every entry to RESP.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q != RESP) begin
      cnt_q <= '0;
    end else if (!dmi_resp_valid_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

  assign dmi_req_o   = req_q;
  assign dmi_clear_o = clear_q;
  assign busy_o      = (state_q != IDLE);
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed self-checking bench for dmi_arbiter: routing, round-robin order, stalls, clear, reset.
module tb_dmi_arbiter;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       dmi_clear_i;
  dmi_req_t   req_i [1:0];
  logic [1:0] req_valid_i;
  logic [1:0] req_ready_o;
  dmi_resp_t  resp_o [1:0];
  logic [1:0] resp_valid_o;
  logic [1:0] resp_ready_i;
  logic [1:0] resp_err_o;
  logic       dmi_clear_o;
  dmi_req_t   dmi_req_o;
  logic       dmi_req_valid_o;
  logic       dmi_req_ready_i;
  dmi_resp_t  dmi_resp_i;
  logic       dmi_resp_valid_i;
  logic       dmi_resp_ready_o;
  logic       busy_o;
  logic       owner_o;

  int checks = 0;
  int errors = 0;
  int acc_cnt [2] = '{0, 0};

  dmi_arbiter #(
    .req_t         (dmi_req_t),
    .resp_t        (dmi_resp_t),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk             (clk),
    .rst_ni          (rst_ni),
    .dmi_clear_i     (dmi_clear_i),
    .req_i           (req_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .resp_o          (resp_o),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_err_o      (resp_err_o),
    .dmi_clear_o     (dmi_clear_o),
    .dmi_req_o       (dmi_req_o),
    .dmi_req_valid_o (dmi_req_valid_o),
    .dmi_req_ready_i (dmi_req_ready_i),
    .dmi_resp_i      (dmi_resp_i),
    .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o),
    .busy_o          (busy_o),
    .owner_o         (owner_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (req_ready_o[0]) acc_cnt[0]++;
    if (req_ready_o[1]) acc_cnt[1]++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ni           = 1'b0;
    dmi_clear_i      = 1'b0;
    req_valid_i      = 2'b00;
    resp_ready_i     = 2'b00;
    dmi_req_ready_i  = 1'b0;
    dmi_resp_i       = '0;
    dmi_resp_valid_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
  endtask

  // One full transaction with both ports requesting; checks the expected winner end to end.
  task automatic xact_both(input int exp_own, input logic [31:0] rdata);
    req_valid_i = 2'b11;
    #1;
    chk($sformatf("rr_grant%0d", exp_own), req_ready_o, (exp_own == 0) ? 2'b01 : 2'b10);
    step();
    req_valid_i     = 2'b00;
    dmi_req_ready_i = 1'b1;
    #1;
    chk("rr_owner", owner_o, exp_own);
    chk("rr_req", dmi_req_o, (exp_own == 0) ? req_i[0] : req_i[1]);
    step();
    dmi_req_ready_i  = 1'b0;
    dmi_resp_i       = '{data: rdata, resp: 2'b00};
    dmi_resp_valid_i = 1'b1;
    resp_ready_i     = 2'b11;
    #1;
    chk("rr_rvalid", resp_valid_o, (exp_own == 0) ? 2'b01 : 2'b10);
    step();
    dmi_resp_valid_i = 1'b0;
  endtask

  initial begin
    req_i[0] = '0;
    req_i[1] = '0;
    do_reset();
    rst_ni = 1'b0;
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_owner", owner_o, 1'b0);
    chk("rst_drain", dmi_resp_ready_o, 1'b1);
    chk("rst_dvalid", dmi_req_valid_o, 1'b0);
    chk("rst_clear", dmi_clear_o, 1'b0);
    chk("rst_rvalid", resp_valid_o, 2'b00);
    step();
    rst_ni = 1'b1;
    step();

    // Lone port-0 read, response routed to port 0 only.
    req_i[0]    = '{addr: 7'h11, op: 2'd1, data: 32'h0};
    req_valid_i = 2'b01;
    #1;
    chk("t1_accept", req_ready_o, 2'b01);
    step();
    req_valid_i = 2'b00;
    #1;
    chk("t1_dvalid", dmi_req_valid_o, 1'b1);
    chk("t1_dreq", dmi_req_o, {7'h11, 2'd1, 32'h0});
    chk("t1_busy", busy_o, 1'b1);
    dmi_req_ready_i = 1'b1;
    step();
    dmi_req_ready_i  = 1'b0;
    dmi_resp_i       = '{data: 32'hCAFE_F00D, resp: 2'b00};
    dmi_resp_valid_i = 1'b1;
    resp_ready_i     = 2'b11;
    #1;
    chk("t1_rvalid", resp_valid_o, 2'b01);
    chk("t1_rdata0", resp_o[0], {32'hCAFE_F00D, 2'b00});
    chk("t1_rdata1", resp_o[1], 34'h0);
    chk("t1_dready", dmi_resp_ready_o, 1'b1);
    step();
    dmi_resp_valid_i = 1'b0;
    #1;
    chk("t1_idle", busy_o, 1'b0);

    // Both ports valid from reset: 0,1,0,1.
    do_reset();
    req_i[0] = '{addr: 7'h20, op: 2'd2, data: 32'h1111_0000};
    req_i[1] = '{addr: 7'h30, op: 2'd2, data: 32'h2222_0000};
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    xact_both(0, 32'h100);
    xact_both(1, 32'h101);
    xact_both(0, 32'h102);
    xact_both(1, 32'h103);
    chk("t2_pulses0", acc_cnt[0], 2);
    chk("t2_pulses1", acc_cnt[1], 2);

    // Downstream stall for 5 cycles; port 1 waits.
    req_valid_i = 2'b11;
    #1;
    chk("t3_grant", req_ready_o, 2'b01);
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t3_hold_v%0d", i), dmi_req_valid_o, 1'b1);
      chk($sformatf("t3_hold_d%0d", i), dmi_req_o, {7'h20, 2'd2, 32'h1111_0000});
      chk($sformatf("t3_noacc%0d", i), req_ready_o, 2'b00);
      step();
    end
    req_valid_i     = 2'b00;
    dmi_req_ready_i = 1'b1;
    step();
    dmi_req_ready_i  = 1'b0;
    dmi_resp_valid_i = 1'b1;
    step();
    dmi_resp_valid_i = 1'b0;

    // Clear while port 1 waits in RESP; late response is drained.
    req_valid_i = 2'b10;
    step();
    req_valid_i     = 2'b00;
    dmi_req_ready_i = 1'b1;
    step();
    dmi_req_ready_i = 1'b0;
    dmi_clear_i     = 1'b1;
    req_valid_i     = 2'b01;
    #1;
    chk("t4_busy_resp", busy_o, 1'b1);
    chk("t4_noacc", req_ready_o, 2'b00);
    chk("t4_noresp", resp_valid_o, 2'b00);
    step();
    dmi_clear_i      = 1'b0;
    req_valid_i      = 2'b00;
    dmi_resp_i       = '{data: 32'hDEAD_BEEF, resp: 2'b00};
    dmi_resp_valid_i = 1'b1;
    #1;
    chk("t4_clear_o", dmi_clear_o, 1'b1);
    chk("t4_idle", busy_o, 1'b0);
    chk("t4_late_drop", resp_valid_o, 2'b00);
    chk("t4_drain", dmi_resp_ready_o, 1'b1);
    step();
    dmi_resp_valid_i = 1'b0;
    #1;
    chk("t4_clear_fall", dmi_clear_o, 1'b0);

    // last_q untouched by clear (was 0), so port 1 wins; then response backpressure.
    req_valid_i = 2'b11;
    #1;
    chk("t4_last_kept", req_ready_o, 2'b10);
    step();
    req_valid_i     = 2'b00;
    dmi_req_ready_i = 1'b1;
    step();
    dmi_req_ready_i  = 1'b0;
    dmi_resp_valid_i = 1'b1;
    resp_ready_i     = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t5_stall_rdy%0d", i), dmi_resp_ready_o, 1'b0);
      chk($sformatf("t5_stall_vld%0d", i), resp_valid_o, 2'b10);
      step();
    end
    resp_ready_i = 2'b10;
    #1;
    chk("t5_go", dmi_resp_ready_o, 1'b1);
    step();
    dmi_resp_valid_i = 1'b0;
    resp_ready_i     = 2'b00;
    #1;
    chk("t5_done", busy_o, 1'b0);

    // Asynchronous reset in REQ.
    req_valid_i = 2'b10;
    step();
    req_valid_i = 2'b00;
    #1;
    chk("rst_mid_pre", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_dvld", dmi_req_valid_o, 1'b0);
    chk("rst_mid_owner", owner_o, 1'b0);
    step();
    rst_ni = 1'b1;
    step();

`ifdef DMI_ARB_TIMEOUT_EN
    // Watchdog: no response for 8 RESP cycles.
    req_valid_i = 2'b01;
    step();
    req_valid_i     = 2'b00;
    dmi_req_ready_i = 1'b1;
    step();
    dmi_req_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("t6_wait%0d", i), resp_valid_o, 2'b00);
      step();
    end
    #1;
    chk("t6_tout_vld", resp_valid_o, 2'b01);
    chk("t6_tout_err", resp_err_o, 2'b01);
    chk("t6_tout_data", resp_o[0], 34'h0);
    resp_ready_i = 2'b01;
    step();
    resp_ready_i = 2'b00;
    req_valid_i  = 2'b11;
    #1;
    chk("t6_next", req_ready_o, 2'b10);
    step();
    req_valid_i = 2'b00;
`else
    chk("t6_err_const", resp_err_o, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
